muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 Port: valid_i  in  1  EX stage holds an M-extension op (opcode 0110011, func7 0000001).
REQ-005 Port: func3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: rs1_i  in  XLEN  operand A.
REQ-007 Port: rs2_i  in  XLEN  operand B.
REQ-008 Port: flush_i  in  1  kill the in-flight op (branch taken / exception).
REQ-009 Port: stall_o  out  1  freeze IF/ID/EX; combinational.
REQ-010 Port: valid_o  out  1  result_o valid this cycle; registered.
REQ-011 Port: result_o  out  XLEN  result for the EX/MEM register; registered.

Function
REQ-012 FSM SHALL have states IDLE, BUSY, DONE.
REQ-013 IDLE: valid_i=1 and flush_i=0 -> accept; latch rs1_i, rs2_i, func3_i; go BUSY; count=0.
REQ-014 Operand changes after acceptance SHALL be ignored.
REQ-015 BUSY SHALL run one iteration per cycle for exactly XLEN cycles: shift-add multiply or restoring divide on magnitudes.
REQ-016 BUSY: count increments each cycle; at count=XLEN-1 -> DONE.
REQ-017 DONE SHALL last one cycle with valid_o=1 and result_o valid, then -> IDLE unconditionally; DONE never accepts.
REQ-018 Latency: accept at cycle T -> valid_o=1 at T+XLEN+1 (T+33) -> earliest next accept at T+XLEN+2.
REQ-019 stall_o = ~rst_i & ~flush_i & ((IDLE & valid_i) | BUSY); stall_o=0 in DONE so the pipeline advances.
REQ-020 Signedness: MULH/DIV/REM signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU/DIVU/REMU unsigned.
REQ-021 Signed ops negate the magnitude result on exit: product or quotient if signs differ; remainder takes the sign of rs1.
REQ-022 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-023 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
REQ-024 Signed overflow: DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-025 Special cases keep full latency T+33; the result is overridden at DONE.
REQ-026 flush_i=1 in any state -> IDLE next cycle; valid_o=0 next cycle; no accept in the flush cycle.
REQ-027 flush_i=1 in DONE SHALL also force valid_o=0 that cycle.
REQ-028 result_o SHALL hold its last value outside DONE; consumers qualify it with valid_o.

Reset
REQ-029 rst_i=1 at a clock edge -> state IDLE, count 0, valid_o 0, result_o 0, latched operands 0.
REQ-030 stall_o=0 whenever rst_i=1.
REQ-031 Reset SHALL dominate flush_i and valid_i.
REQ-032 Reset mid-BUSY or in DONE SHALL abort the op with no valid_o pulse.
REQ-033 First accept is possible on the first edge with rst_i=0.

Verification
REQ-034 MUL: rs1=7, rs2=6 accepted at T -> stall_o=1 through T+32, valid_o=1 and result_o=42 at T+33, stall_o=0 at T+33.
REQ-035 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; all at T+33.
REQ-038 flush_i=1 at BUSY count=10 -> IDLE next cycle, no valid_o; new MUL 3x3 accepted next cycle -> 9 after 33 cycles.
REQ-039 rst_i=1 at BUSY count=20 -> IDLE, valid_o=0, result_o=0; a subsequent DIVU 9/3 -> 3 at T+33.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RISC-V M-extension unit. A shift-add multiplier or
//               restoring divider works on operand magnitudes, one step per
//               cycle, for XLEN cycles. The sign is applied when the result
//               is registered. Divide-by-zero and signed-overflow results
//               replace the computed value in that same step, so every op
//               has the same latency.
// Ports       : clk_i      - clock; all state changes on the rising edge
//               rst_i      - synchronous active-high reset
//               valid_i    - EX stage holds an M-extension op
//               func3_i    - op select (MUL..REMU)
//               rs1_i      - operand A
//               rs2_i      - operand B
//               flush_i    - kill the in-flight op
//               stall_o    - freeze IF/ID/EX (combinational)
//               valid_o    - result_o valid this cycle
//               result_o   - registered result for EX/MEM
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int c_CW = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_count;

    // Latched op and raw operands (raw values feed the special-case results)
    logic [2:0]      r_func3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_neg_a;
    logic            r_neg_b;

    // Datapath: r_mag_b is multiplicand / divisor; {r_hi, r_lo} is the
    // product shift register or the {remainder, quotient} pair.
    logic [XLEN-1:0] r_mag_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_last;
    logic            w_signed_a;
    logic            w_signed_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_final;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_accept = (r_state == c_IDLE) & valid_i & ~flush_i;
    assign w_last   = (r_state == c_BUSY) & (r_count == c_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (valid_i) w_next_state = c_BUSY;
            c_BUSY:  if (r_count == c_LAST) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
        if (flush_i) begin
            w_next_state = c_IDLE;
        end
    end

    assign stall_o = ~rst_i & ~flush_i &
                     (((r_state == c_IDLE) & valid_i) | (r_state == c_BUSY));

    // A flush or reset during DONE suppresses the pulse in that same cycle.
    assign valid_o  = (r_state == c_DONE) & ~flush_i & ~rst_i;
    assign result_o = r_result;

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    assign w_signed_a = (func3_i == 3'b001) | (func3_i == 3'b010) |
                        (func3_i == 3'b100) | (func3_i == 3'b110);
    assign w_signed_b = (func3_i == 3'b001) | (func3_i == 3'b100) |
                        (func3_i == 3'b110);
    assign w_neg_a    = w_signed_a & rs1_i[XLEN-1];
    assign w_neg_b    = w_signed_b & rs2_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -rs1_i : rs1_i;
    assign w_mag_b    = w_neg_b ? -rs2_i : rs2_i;

    // ------------------------------------------------------------------
    // One iteration
    // ------------------------------------------------------------------
    // Multiply: add the multiplicand when the low multiplier bit is set,
    // then shift the 65-bit {carry, hi, lo} right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract. The remainder stays below the divisor, so the top bit of the
    // 33-bit difference is a reliable borrow flag.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_func3[2]) begin
            if (!w_div_diff[XLEN]) begin
                w_step_hi = w_div_diff[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[XLEN-1:0];
                w_step_lo = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_mul_sum[XLEN:1];
            w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final result, taken from the last iteration's outputs
    // ------------------------------------------------------------------
    assign w_prod   = {w_step_hi, w_step_lo};
    assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_b_zero = (r_rs2 == '0);
    assign w_ovf    = (r_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (r_rs2 == {XLEN{1'b1}});

    always_comb begin
        w_final = '0;
        case (r_func3)
            3'b000: w_final = w_prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100: begin
                if (w_b_zero)     w_final = {XLEN{1'b1}};
                else if (w_ovf)   w_final = {1'b1, {(XLEN-1){1'b0}}};
                else              w_final = (r_neg_a ^ r_neg_b) ? -w_step_lo : w_step_lo;
            end
            3'b101: w_final = w_b_zero ? {XLEN{1'b1}} : w_step_lo;
            3'b110: begin
                if (w_b_zero)     w_final = r_rs1;
                else if (w_ovf)   w_final = '0;
                else              w_final = r_neg_a ? -w_step_hi : w_step_hi;
            end
            3'b111: w_final = w_b_zero ? r_rs1 : w_step_hi;
            default: w_final = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_func3 <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_mag_b <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept) begin
            r_count <= '0;
            r_func3 <= func3_i;
            r_rs1   <= rs1_i;
            r_rs2   <= rs2_i;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_mag_b <= w_mag_b;
            r_hi    <= '0;
            r_lo    <= w_mag_a;
        end else if (r_state == c_BUSY) begin
            r_count <= r_count + c_ONE;
            r_hi    <= w_step_hi;
            r_lo    <= w_step_lo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else if (w_last && !flush_i) begin
            r_result <= w_final;
        end
    end

endmodule
`default_nettype wire
